// File: rtl/cache_pkg.sv
// Shared types and default geometry for the set-associative cache controller.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE_MEM} state_t;

  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_WAYS        = 2;
  localparam int DEF_SETS        = 8;
  localparam int DEF_BLOCK_WORDS = 4;

  localparam int OFF_W = $clog2(DEF_BLOCK_WORDS);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_WIDTH - IDX_W - OFF_W;

  // Way-pointer width; a direct-mapped build still needs one bit to hold way 0.
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid bit and tag plus the data words of every line.
// Lookup is combinational; all writes land on the rising edge.
module cache_way
  import cache_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SETS        = DEF_SETS,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int TAG_BITS    = TAG_W,
  localparam int IW = $clog2(SETS),
  localparam int OW = $clog2(BLOCK_WORDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IW-1:0]       idx,
  input  logic [TAG_BITS-1:0] lookupTag,
  input  logic [OW-1:0]       lookupOff,
  input  logic [OW-1:0]       wrOff,
  input  logic [WIDTH-1:0]    wrData,
  input  logic                fillWrEn,
  input  logic                storeEn,
  input  logic                tagWrEn,
  output logic                hit,
  output logic                lineValid,
  output logic [WIDTH-1:0]    rdWord
);

  logic [SETS-1:0]     validReg;
  logic [TAG_BITS-1:0] tagMem [SETS];
  logic [WIDTH-1:0]    dataMem [SETS*BLOCK_WORDS];
  logic                wordWrEn;

  assign lineValid = validReg[idx];
  assign hit       = lineValid && (tagMem[idx] == lookupTag);
  assign rdWord    = dataMem[{idx, lookupOff}];
  // A store only touches this way when the line is already resident here.
  assign wordWrEn  = fillWrEn | (storeEn & hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      validReg <= '0;
    end else if (tagWrEn) begin
      validReg[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tagWrEn) tagMem[idx] <= lookupTag;
    if (wordWrEn) dataMem[{idx, wrOff}] <= wrData;
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative, write-through, write-no-allocate cache controller.
// Read misses fill a whole line via req/ack memory reads; every store goes through to memory.
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int WAYS        = DEF_WAYS,
  parameter int SETS        = DEF_SETS,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] WordAddress,
  input  logic [WIDTH-1:0]      DataIn,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  stall,
  output logic [WIDTH-1:0]      DataOut,
  output logic [ADDR_WIDTH-1:0] mm_addr,
  output logic [WIDTH-1:0]      mm_wdata,
  output logic                  mm_rd_req,
  output logic                  mm_wr_req,
  input  logic [WIDTH-1:0]      mm_rdata,
  input  logic                  mm_ack
);

  localparam int offW = $clog2(BLOCK_WORDS);
  localparam int idxW = $clog2(SETS);
  localparam int tagW = ADDR_WIDTH - idxW - offW;
  localparam int ptrW = ptrWidth(WAYS);

  state_t            stateReg, stateNext;
  logic [offW-1:0]   fillCnt, nextOff, wrOff;
  logic [ptrW-1:0]   victimReg, victimSel;
  logic [ptrW-1:0]   rrPtr [SETS];
  logic              victimByRr, foundInvalid, wrDoneReg;
  logic [WIDTH-1:0]  captReg, hitWord, wrData;
  logic [WIDTH-1:0]  wayWord [WAYS];
  logic [WAYS-1:0]   hitVec, validVec;
  logic              anyHit, reqLive, startWrite, startFill, readHit;
  logic              fillAck, fillLast, writeAck;

  logic [tagW-1:0] addrTag;
  logic [idxW-1:0] addrIdx;
  logic [offW-1:0] addrOff;
  assign addrTag = WordAddress[ADDR_WIDTH-1 -: tagW];
  assign addrIdx = WordAddress[offW +: idxW];
  assign addrOff = WordAddress[offW-1:0];

  // The cycle after a write ack the still-held store is the completed one, so it is not re-accepted.
  assign reqLive    = (stateReg == IDLE) && !wrDoneReg;
  assign anyHit     = |hitVec;
  assign startWrite = reqLive && mem_write;
  assign startFill  = reqLive && !mem_write && mem_read && !anyHit;
  assign readHit    = reqLive && !mem_write && mem_read && anyHit;
  assign fillAck    = (stateReg == FILL) && mm_rd_req && mm_ack;
  assign fillLast   = fillAck && (fillCnt == offW'(BLOCK_WORDS - 1));
  assign writeAck   = (stateReg == WRITE_MEM) && mm_wr_req && mm_ack;
  assign nextOff    = fillCnt + 1'b1;
  assign wrOff      = (stateReg == FILL) ? fillCnt : addrOff;
  assign wrData     = (stateReg == FILL) ? mm_rdata : DataIn;

  always_comb begin
    stateNext = stateReg;
    stall     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (startWrite) begin
          stall     = 1'b1;
          stateNext = WRITE_MEM;
        end else if (startFill) begin
          stall     = 1'b1;
          stateNext = FILL;
        end
      end
      FILL: begin
        stall = 1'b1;
        if (fillLast) stateNext = IDLE;
      end
      WRITE_MEM: begin
        stall = 1'b1;
        if (writeAck) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Lowest-index invalid way wins; otherwise fall back to the set's round-robin pointer.
  always_comb begin
    victimSel    = rrPtr[addrIdx];
    foundInvalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!validVec[w]) begin
        victimSel    = ptrW'(w);
        foundInvalid = 1'b1;
      end
    end
  end

  always_comb begin
    hitWord = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hitVec[w]) hitWord = hitWord | wayWord[w];
    end
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : genWay
    logic selVictim;
    assign selVictim = (victimReg == ptrW'(gi));
    cache_way #(
      .WIDTH(WIDTH), .SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS), .TAG_BITS(tagW)
    ) uWay (
      .clk(clk), .reset(reset), .idx(addrIdx), .lookupTag(addrTag), .lookupOff(addrOff),
      .wrOff(wrOff), .wrData(wrData), .fillWrEn(fillAck && selVictim), .storeEn(startWrite),
      .tagWrEn(fillLast && selVictim), .hit(hitVec[gi]), .lineValid(validVec[gi]),
      .rdWord(wayWord[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      fillCnt    <= '0;
      victimReg  <= '0;
      victimByRr <= 1'b0;
      wrDoneReg  <= 1'b0;
      captReg    <= '0;
      DataOut    <= '0;
      mm_addr    <= '0;
      mm_wdata   <= '0;
      mm_rd_req  <= 1'b0;
      mm_wr_req  <= 1'b0;
      for (int s = 0; s < SETS; s++) rrPtr[s] <= '0;
    end else begin
      stateReg  <= stateNext;
      wrDoneReg <= writeAck;
      if (readHit) DataOut <= hitWord;
      if (startWrite) begin
        mm_wr_req <= 1'b1;
        mm_addr   <= WordAddress;
        mm_wdata  <= DataIn;
      end
      if (writeAck) mm_wr_req <= 1'b0;
      if (startFill) begin
        mm_rd_req  <= 1'b1;
        mm_addr    <= {addrTag, addrIdx, {offW{1'b0}}};
        fillCnt    <= '0;
        victimReg  <= victimSel;
        victimByRr <= !foundInvalid;
      end
      if (fillAck) begin
        if (fillCnt == addrOff) captReg <= mm_rdata;
        if (fillLast) begin
          mm_rd_req <= 1'b0;
          DataOut   <= (fillCnt == addrOff) ? mm_rdata : captReg;
          if (WAYS > 1 && victimByRr) rrPtr[addrIdx] <= rrPtr[addrIdx] + 1'b1;
        end else begin
          fillCnt <= nextOff;
          mm_addr <= {addrTag, addrIdx, nextOff};
        end
      end
    end
  end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed + random bench for set_assoc_cache_ctrl against a tag-level cache model and a word memory.
module tb_set_assoc_cache_ctrl;

  localparam int AW = 10, DW = 32, WAYS = 2, SETS = 8, BW = 4;
  localparam int OFFB = 2, IDXB = 3, TAGB = 5;

  logic clk = 1'b0, reset = 1'b1;
  logic [AW-1:0] WordAddress = '0;
  logic [DW-1:0] DataIn = '0;
  logic mem_read = 1'b0, mem_write = 1'b0;
  logic stall, mm_rd_req, mm_wr_req;
  logic [DW-1:0] DataOut, mm_wdata;
  logic [AW-1:0] mm_addr;
  logic [DW-1:0] mm_rdata = '0;
  logic mm_ack = 1'b0;

  int nVec = 0, nMis = 0;
  int age = 0;
  logic [DW-1:0] simMem [int];
  logic [DW-1:0] refMem [int];
  logic [AW-1:0] rdLog [$];
  logic [AW-1:0] wrAddrLog [$];
  logic [DW-1:0] wrDataLog [$];
  bit refValid [SETS][WAYS];
  int refTag [SETS][WAYS];
  int refRr [SETS];

  set_assoc_cache_ctrl #(
    .ADDR_WIDTH(AW), .WIDTH(DW), .WAYS(WAYS), .SETS(SETS), .BLOCK_WORDS(BW)
  ) dut (
    .clk(clk), .reset(reset), .WordAddress(WordAddress), .DataIn(DataIn),
    .mem_read(mem_read), .mem_write(mem_write), .stall(stall), .DataOut(DataOut),
    .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rd_req(mm_rd_req), .mm_wr_req(mm_wr_req),
    .mm_rdata(mm_rdata), .mm_ack(mm_ack)
  );

  always #5 clk = ~clk;

  // Main memory: mem[a] = a*3 until written; acks a held request after three cycles.
  always @(negedge clk) begin
    if (reset || mm_ack) begin
      mm_ack <= 1'b0;
      age    <= 0;
    end else if (mm_rd_req || mm_wr_req) begin
      age <= age + 1;
      if (age == 2) begin
        mm_ack <= 1'b1;
        if (mm_wr_req) begin
          simMem[int'(mm_addr)] = mm_wdata;
          wrAddrLog.push_back(mm_addr);
          wrDataLog.push_back(mm_wdata);
        end else begin
          mm_rdata <= simMem.exists(int'(mm_addr)) ? simMem[int'(mm_addr)] : DW'(int'(mm_addr) * 3);
          rdLog.push_back(mm_addr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitIdle(input string tag);
    int cyc = 0;
    while (stall !== 1'b0 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (cyc >= 200) chk({tag, "_timeout"}, stall, 0);
  endtask

  function automatic logic [DW-1:0] refGet(input logic [AW-1:0] a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : DW'(int'(a) * 3);
  endfunction

  function automatic bit refHit(input logic [AW-1:0] a);
    int s = int'(a[OFFB +: IDXB]);
    int t = int'(a[AW-1 -: TAGB]);
    for (int w = 0; w < WAYS; w++) if (refValid[s][w] && refTag[s][w] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void refFill(input logic [AW-1:0] a);
    int s = int'(a[OFFB +: IDXB]);
    int v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!refValid[s][w]) v = w;
    if (v < 0) begin
      v = refRr[s];
      refRr[s] = (refRr[s] + 1) % WAYS;
    end
    refValid[s][v] = 1'b1;
    refTag[s][v] = int'(a[AW-1 -: TAGB]);
  endfunction

  function automatic void refClear();
    for (int s = 0; s < SETS; s++) begin
      refRr[s] = 0;
      for (int w = 0; w < WAYS; w++) refValid[s][w] = 1'b0;
    end
  endfunction

  task automatic doRead(input logic [AW-1:0] a, input string tag);
    int rd0 = rdLog.size();
    bit expHit = refHit(a);
    WordAddress = a; mem_read = 1'b1; mem_write = 1'b0; DataIn = $urandom;
    #1;
    chk({tag, "_stall"}, stall, !expHit);
    if (expHit) chk({tag, "_noreq"}, mm_rd_req, 0);
    waitIdle(tag);
    tick();
    mem_read = 1'b0;
    chk({tag, "_data"}, DataOut, refGet(a));
    chk({tag, "_nreads"}, rdLog.size() - rd0, expHit ? 0 : BW);
    if (!expHit) begin
      for (int k = 0; k < BW; k++)
        if (rd0 + k < rdLog.size()) chk({tag, "_raddr"}, rdLog[rd0 + k], {a[AW-1:OFFB], OFFB'(k)});
      refFill(a);
    end
    $display("%s: read %h hit=%0b data=%h", tag, a, expHit, DataOut);
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    int rd0 = rdLog.size();
    int wr0 = wrAddrLog.size();
    WordAddress = a; DataIn = d; mem_write = 1'b1; mem_read = 1'($urandom_range(0, 1));
    #1;
    chk({tag, "_stall"}, stall, 1);
    waitIdle(tag);
    tick();
    mem_write = 1'b0; mem_read = 1'b0;
    chk({tag, "_nwrites"}, wrAddrLog.size() - wr0, 1);
    chk({tag, "_nreads"}, rdLog.size() - rd0, 0);
    if (wrAddrLog.size() > wr0) begin
      chk({tag, "_waddr"}, wrAddrLog[wr0], a);
      chk({tag, "_wdata"}, wrDataLog[wr0], d);
    end
    refMem[int'(a)] = d;
    $display("%s: write %h data=%h", tag, a, d);
  endtask

  initial begin
    int rd0, cyc;
    logic [AW-1:0] ra;
    refClear();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_dataout", DataOut, 0);
    chk("rst_rdreq", mm_rd_req, 0);
    chk("rst_wrreq", mm_wr_req, 0);
    chk("rst_mmaddr", mm_addr, 0);
    chk("rst_mmwdata", mm_wdata, 0);
    reset = 1'b0;
    $display("reset: stall=%0b DataOut=%h", stall, DataOut);

    doRead(10'h000, "t1_rd000");
    doRead(10'h025, "t2_rd025");
    chk("t2_const025", DataOut, 32'h6F);
    doRead(10'h026, "t2_rd026");
    chk("t2_const026", DataOut, 32'h72);

    doWrite(10'h025, 32'hDEADBEEF, "t4_wr025");
    doRead(10'h025, "t4_rd025");
    chk("t4_const025", DataOut, 32'hDEADBEEF);

    doRead(10'h025, "t3_rd025");
    doRead(10'h065, "t3_rd065");
    doRead(10'h0A5, "t3_rd0A5");
    doRead(10'h065, "t3_rehit065");
    chk("t3_const065", DataOut, 32'h12F);
    doRead(10'h025, "t3_refill025");

    doWrite(10'h3FF, 32'h7, "t5_wr3FF");
    doRead(10'h3FF, "t5_rd3FF");
    chk("t5_const3FF", DataOut, 32'h7);

    for (int i = 0; i < 40; i++) begin
      ra = AW'(($urandom_range(0, 3) << (OFFB + IDXB)) | $urandom_range(0, 31));
      if ($urandom_range(0, 9) < 3) doWrite(ra, $urandom, "rnd_wr");
      else doRead(ra, "rnd_rd");
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    refClear();
    rd0 = rdLog.size();
    WordAddress = 10'h025; mem_read = 1'b1;
    cyc = 0;
    while (rdLog.size() - rd0 < 2 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (cyc >= 200) chk("t6_fill_timeout", rdLog.size() - rd0, 2);
    reset = 1'b1; mem_read = 1'b0;
    tick();
    chk("t6_stall", stall, 0);
    chk("t6_rdreq", mm_rd_req, 0);
    reset = 1'b0;
    refClear();
    $display("t6: reset mid-fill, stall=%0b mm_rd_req=%0b", stall, mm_rd_req);
    doRead(10'h025, "t6_reread025");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
